// File: rtl/im_pkg.sv
// Shared types and constants for the instruction-memory loader.
package im_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } im_state_e;

  localparam int IM_ADDR_W      = 8;
  localparam int BYTES_PER_WORD = 4;

  // Big-endian byte select: index 0 is bits [31:24].
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/im_loader.sv
// Streams 32-bit instruction words into a byte-wide memory write port, one byte per cycle.
// Optional running checksum of written bytes is enabled by defining IM_LOADER_CHECKSUM_EN.
//
// state     | meaning
// ST_IDLE   | waiting for start after reset
// ST_ACCEPT | word_ready high, waiting for the next word
// ST_WRITE  | emitting the latched word one byte per cycle
// ST_DONE   | last word written; waiting for the next start
module im_loader
  import im_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef IM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  im_state_e         r_state;
  im_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [1:0]        r_idx;
  logic [31:0]       r_word;
  logic              r_last;
  logic              r_overflow;
  logic [7:0]        w_byte;

  assign w_byte   = word_byte(r_word, r_idx);
  assign overflow = r_overflow;

  always_comb begin
    w_state_nxt = r_state;
    word_ready  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        done = (r_state == ST_DONE);
        if (start) w_state_nxt = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        word_ready = 1'b1;
        busy       = 1'b1;
        if (word_valid) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_ptr;
        mem_wdata = w_byte;
        if (r_idx == LAST_IDX) w_state_nxt = r_last ? ST_DONE : ST_ACCEPT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_last     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_ptr      <= base_addr;
            r_overflow <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (word_valid) begin
            r_word <= word_data;
            r_last <= word_last;
            r_idx  <= '0;
          end
        end
        ST_WRITE: begin
          r_ptr <= r_ptr + 1'b1;
          r_idx <= r_idx + 1'b1;
          // Pointer wraps modulo the memory size; the wrap is only flagged, writes go on.
          if (r_ptr == '1) r_overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if ((r_state == ST_IDLE || r_state == ST_DONE) && start) begin
      r_checksum <= '0;
    end else if (r_state == ST_WRITE) begin
      r_checksum <= r_checksum + w_byte;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; memory depth is 2**ADDR_W bytes.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  pulse that begins a load session at base_addr.
REQ-005 base_addr  input  ADDR_W  first byte address written in a session.
REQ-006 word_valid  input  1  upstream presents an instruction word.
REQ-007 word_data  input  32  instruction word; bits [31:24] are the lowest byte address (big-endian).
REQ-008 word_last  input  1  qualifies word_data as the final word of the session.
REQ-009 word_ready  output  1  loader can accept a word this cycle.
REQ-010 mem_we  output  1  byte write strobe to the instruction-memory write port.
REQ-011 mem_addr  output  ADDR_W  byte address of the write.
REQ-012 mem_wdata  output  8  byte written.
REQ-013 busy  output  1  session in progress (ACCEPT or WRITE).
REQ-014 done  output  1  session finished; held until the next start.
REQ-015 overflow  output  1  sticky flag: the write pointer wrapped past 2**ADDR_W-1.
REQ-016 checksum  output  8  mod-256 sum of written bytes (present only with the macro).

Function
REQ-017 The FSM SHALL have states IDLE, ACCEPT, WRITE and DONE.
REQ-018 IDLE/DONE + start: ptr<=base_addr, overflow<=0, done<=0, checksum<=0, go to ACCEPT.
REQ-019 ACCEPT: word_ready=1; on word_valid&&word_ready, latch word_data and word_last, byte index<=0, go to WRITE.
REQ-020 WRITE: mem_we=1 each cycle, mem_addr=ptr, mem_wdata=byte[idx], idx 0 -> bits[31:24] ... idx 3 -> bits[7:0]; ptr increments by 1 each cycle.
REQ-021 After idx 3: go to DONE if the latched last=1, else to ACCEPT.
REQ-022 Timing: first mem_we is asserted the cycle after the handshake; sustained rate is 1 word per 5 cycles.
REQ-023 word_ready SHALL be 0 in IDLE, WRITE and DONE.
REQ-024 ptr wraps 2**ADDR_W-1 -> 0 modulo; the wrap sets overflow, and writes continue.
REQ-025 start in ACCEPT or WRITE SHALL be ignored.
REQ-026 word_valid in IDLE or DONE SHALL be ignored; no write occurs.
REQ-027 mem_addr and mem_wdata are don't-care when mem_we=0 but SHALL be driven to 0.
REQ-028 busy=1 exactly in ACCEPT and WRITE; done=1 exactly in DONE.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, ptr=0, idx=0, mem_we=0, word_ready=0, busy=0, done=0, overflow=0, checksum=0.
REQ-030 Reset during WRITE SHALL abort with no further mem_we; the partially written word is not completed.

Configuration
REQ-031 Macro IM_LOADER_CHECKSUM_EN defined: the checksum port exists and adds mem_wdata mod 256 on every mem_we cycle; it is cleared by start and by reset.
REQ-032 Macro not defined: the checksum port and its logic are absent; all other behaviour is identical.

Structure
REQ-033 Shared package im_pkg SHALL hold the FSM state enum, IM_ADDR_W=8, and BYTES_PER_WORD=4.
REQ-034 The block SHALL be a single module with no sub-module; the instruction-memory write port is external.

Verification
REQ-035 Reset release, start with base_addr=0x00, one word 0x12345678 with last=1 -> writes (0x00,0x12), (0x01,0x34), (0x02,0x56), (0x03,0x78) on 4 consecutive cycles, then done=1.
REQ-036 Three back-to-back words with valid held high, base 0x10 -> 12 writes at 0x10..0x1B; word_ready pulses once every 5 cycles.
REQ-037 base_addr=0xFE, one word 0xAABBCCDD with last=1 -> writes at 0xFE, 0xFF, 0x00, 0x01; overflow=1 and remains 1 after done.
REQ-038 Assert rst_n low after the 2nd byte of a word -> no further mem_we and all outputs at reset values; the next start restarts cleanly.
REQ-039 start pulsed during WRITE and word_valid during DONE -> both ignored; addresses and write count unchanged.
REQ-040 With IM_LOADER_CHECKSUM_EN, word 0x01020304 -> checksum=0x0A; word 0xFFFFFFFF -> checksum=0xFC.
